router_port_fifo_fc: RTL

- Parametrised single-port NoC input buffer with selectable flow-control mode. Intended as the drop-in port stage for the next-generation router.
- Sits between a link (data/void/stop) and a router crossbar input, or back-to-back with another link.
- Generalises the fixed 4-deep ack/nack port queue in three ways: configurable width, configurable depth, and an optional credit-based mode.
- Adds early-stop margin, occupancy reporting and sticky protocol-error flags.

---
 rtl/noc_pkg.sv | 20 ++
 rtl/router_port_credit_cnt.sv | 55 +++++
 rtl/router_port_fifo_fc.sv | 131 +++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc (package)
// Description : Shared NoC link definitions: flow-control modes and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package noc;

    typedef enum logic [0:0] {
        kFlowControlAckNack = 1'b0,
        kFlowControlCredits = 1'b1
    } flow_control_e;

    // Bits needed to hold a credit count in the range 0..credits inclusive.
    function automatic int credit_cnt_width(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_port_credit_cnt.sv
`default_nettype none
// ============================================================================
// Module      : router_port_credit_cnt
// Description : Downstream credit counter with saturation and sticky error.
// Revision    : 1.0 - initial release
// ============================================================================
module router_port_credit_cnt
    import noc::*;
#(
    parameter int CREDITS = 4,
    parameter int CNT_W   = credit_cnt_width(CREDITS)
) (
    input  logic clk,
    input  logic rst,
    input  logic transfer,
    input  logic credit_ret,
    output logic credit_avail,
    output logic credit_err
);

    localparam logic [CNT_W-1:0] C_CREDITS = CNT_W'(CREDITS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (transfer && !credit_ret) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (!transfer && credit_ret) begin
            // A return with every credit already home is a protocol error.
            if (cnt_q == C_CREDITS) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= C_CREDITS;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign credit_avail = (cnt_q != '0);
    assign credit_err   = err_q;

endmodule
`default_nettype wire

// File: rtl/router_port_fifo_fc.sv
`default_nettype none
// ============================================================================
// Module      : router_port_fifo_fc
// Description : NoC input port buffer with ack/nack or credit flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module router_port_fifo_fc
    import noc::*;
#(
    parameter int            Width       = 32,
    parameter int            QUEUE_SIZE  = 4,
    parameter flow_control_e FlowControl = kFlowControlAckNack,
    parameter int            STOP_MARGIN = 1,
    parameter int            CREDITS     = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [Width-1:0]                data_in,
    input  logic                            data_void_in,
    output logic                            stop_out,
    output logic [Width-1:0]                data_out,
    output logic                            data_void_out,
    input  logic                            stop_in,
    output logic [$clog2(QUEUE_SIZE+1)-1:0] occupancy,
    output logic                            overflow_err,
    output logic                            credit_err
);

    localparam int AW   = $clog2(QUEUE_SIZE);
    localparam int CNTW = $clog2(QUEUE_SIZE + 1);
    localparam logic [CNTW-1:0] C_FULL     = CNTW'(QUEUE_SIZE);
    localparam logic [CNTW-1:0] C_STOP_THR = CNTW'(QUEUE_SIZE - STOP_MARGIN);

    if ((QUEUE_SIZE < 2) || ((QUEUE_SIZE & (QUEUE_SIZE - 1)) != 0)) begin : g_bad_depth
        $error("QUEUE_SIZE must be a power of two and >= 2");
    end
    if ((STOP_MARGIN < 1) || (STOP_MARGIN > QUEUE_SIZE - 1)) begin : g_bad_margin
        $error("STOP_MARGIN must lie in 1..QUEUE_SIZE-1");
    end
    if (CREDITS < 1) begin : g_bad_credits
        $error("CREDITS must be >= 1");
    end

    logic [Width-1:0] mem [QUEUE_SIZE];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             stop_out_q, stop_out_d;
    logic             overflow_q, overflow_d;
    logic             empty, void_out, enq, deq, credit_avail;

    if (FlowControl == kFlowControlCredits) begin : g_credits
        router_port_credit_cnt #(
            .CREDITS      (CREDITS)
        ) u_credit_cnt (
            .clk          (clk),
            .rst          (rst),
            .transfer     (deq),
            .credit_ret   (stop_in),
            .credit_avail (credit_avail),
            .credit_err   (credit_err)
        );
    end else begin : g_acknack
        assign credit_avail = 1'b1;
        assign credit_err   = 1'b0;
    end

    always_comb begin
        empty      = (count_q == '0);
        void_out   = empty;
        deq        = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        stop_out_d = 1'b0;

        if (FlowControl == kFlowControlCredits) begin
            void_out = empty || !credit_avail;
            deq      = !void_out;
        end else begin
            deq      = !void_out && !stop_in;
        end

        // A dequeue in the same cycle frees the slot, so a full queue still accepts.
        enq = !data_void_in && ((count_q < C_FULL) || deq);
        if (!data_void_in && !enq) begin
            overflow_d = 1'b1;
        end

        if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
        if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CNTW'(enq) - CNTW'(deq);

        if (FlowControl == kFlowControlCredits) begin
            stop_out_d = deq;
        end else begin
            stop_out_d = (count_d >= C_STOP_THR);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stop_out_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stop_out_q <= stop_out_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign data_void_out = void_out;
    assign data_out      = void_out ? '0 : mem[rd_ptr_q];
    assign stop_out      = stop_out_q;
    assign occupancy     = count_q;
    assign overflow_err  = overflow_q;

endmodule
`default_nettype wire
